// File: rtl/tcdm_req_arbiter_pkg.sv
// Shared widths, helpers and payload bundles
// for the TCDM request arbiter.
package tcdm_req_arbiter_pkg;

  localparam int unsigned DefMetaIdWidth = 6;
  localparam int unsigned BusDataWidth = 32;
  localparam int unsigned BusStrbWidth = BusDataWidth / 8;

  function automatic int unsigned idx_width(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                    write;
    logic [3:0]              amo;
    logic [BusDataWidth-1:0] data;
    logic [BusStrbWidth-1:0] strb;
  } dreq_t;

  typedef struct packed {
    logic [BusDataWidth-1:0] data;
    logic                    error;
  } dresp_t;

endpackage

// File: rtl/tcdm_req_arbiter_if.sv
// Core-side TCDM data port: request channel plus
// out-of-order response channel tagged by MetaId.
interface tcdm_req_arbiter_if
  import tcdm_req_arbiter_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = BusDataWidth,
  parameter int unsigned MetaIdWidth = DefMetaIdWidth
);

  localparam int unsigned StrbWidth = DataWidth / 8;

  logic [AddrWidth-1:0]   qaddr;
  logic                   qwrite;
  logic [3:0]             qamo;
  logic [DataWidth-1:0]   qdata;
  logic [StrbWidth-1:0]   qstrb;
  logic [MetaIdWidth-1:0] qid;
  logic                   qvalid;
  logic                   qready;
  logic [DataWidth-1:0]   pdata;
  logic                   perror;
  logic [MetaIdWidth-1:0] pid;
  logic                   pvalid;
  logic                   pready;

  modport master (
    output qaddr, qwrite, qamo, qdata, qstrb,
    output qid, qvalid, pready,
    input  qready, pdata, perror, pid, pvalid
  );

  modport slave (
    input  qaddr, qwrite, qamo, qdata, qstrb,
    input  qid, qvalid, pready,
    output qready, pdata, perror, pid, pvalid
  );

endinterface

// File: rtl/tcdm_req_arbiter_rr_sel_lock.sv
// Round-robin grant search over an eligibility mask,
// holding the grant while the downstream port stalls.
module tcdm_req_arbiter_rr_sel_lock #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned SelWidth = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumReq-1:0]   elig_i,
  input  logic                hs_i,
  input  logic                stall_i,
  output logic [SelWidth-1:0] sel_o,
  output logic                gnt_o
);

  logic [SelWidth-1:0] rr_ptr_q;
  logic [SelWidth-1:0] locked_sel_q;
  logic [SelWidth-1:0] srch_sel;
  logic [SelWidth-1:0] nxt_ptr;
  logic                lock_q;
  logic                srch_hit;

  always_comb begin
    logic [SelWidth-1:0] cand;
    srch_sel = '0;
    srch_hit = 1'b0;
    cand     = '0;
    for (int k = 0; k < int'(NumReq); k++) begin
      cand = SelWidth'((int'(rr_ptr_q) + k) % int'(NumReq));
      if (!srch_hit && elig_i[cand]) begin
        srch_hit = 1'b1;
        srch_sel = cand;
      end
    end
  end

  assign sel_o = lock_q ? locked_sel_q : srch_sel;
  assign gnt_o = lock_q ? elig_i[locked_sel_q] : srch_hit;

  assign nxt_ptr = (sel_o == SelWidth'(NumReq - 1))
                 ? '0 : sel_o + SelWidth'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      locked_sel_q <= '0;
    end else if (hs_i) begin
      lock_q   <= 1'b0;
      rr_ptr_q <= nxt_ptr;
    end else if (stall_i) begin
      lock_q       <= 1'b1;
      locked_sel_q <= sel_o;
    end
  end

endmodule

// File: rtl/tcdm_req_arbiter.sv
// Shares one TCDM data port between NumReq requesters:
// round-robin requests, index-tagged out-of-order responses.
module tcdm_req_arbiter
  import tcdm_req_arbiter_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MetaIdWidth = DefMetaIdWidth,
  parameter int unsigned MaxOutstanding = 8,
  localparam int unsigned StrbWidth = DataWidth / 8,
  localparam int unsigned ReqSelWidth = idx_width(NumReq),
  localparam int ReqIdWidth =
    int'(MetaIdWidth) - int'(ReqSelWidth)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic [NumReq-1:0][AddrWidth-1:0]  req_qaddr_i,
  input  logic [NumReq-1:0]                 req_qwrite_i,
  input  logic [NumReq-1:0][3:0]            req_qamo_i,
  input  logic [NumReq-1:0][DataWidth-1:0]  req_qdata_i,
  input  logic [NumReq-1:0][StrbWidth-1:0]  req_qstrb_i,
  input  logic [NumReq-1:0][ReqIdWidth-1:0] req_qid_i,
  input  logic [NumReq-1:0]                 req_qvalid_i,
  output logic [NumReq-1:0]                 req_qready_o,
  output logic [NumReq-1:0][DataWidth-1:0]  req_pdata_o,
  output logic [NumReq-1:0]                 req_perror_o,
  output logic [NumReq-1:0][ReqIdWidth-1:0] req_pid_o,
  output logic [NumReq-1:0]                 req_pvalid_o,
  input  logic [NumReq-1:0]                 req_pready_i,
  tcdm_req_arbiter_if.master                data,
  output logic                              id_err_o
);

  localparam int unsigned CntWidth =
    $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] CntMax =
    CntWidth'(MaxOutstanding);

  if (NumReq < 2) begin : g_err_numreq
    $fatal(1, "NumReq must be at least 2");
  end
  if (ReqIdWidth < 1) begin : g_err_idw
    $fatal(1, "ReqIdWidth must be at least 1");
  end
  if (DataWidth != 32) begin : g_err_dw
    $fatal(1, "DataWidth must be 32");
  end

  logic [CntWidth-1:0]    cnt_q [NumReq];
  logic [NumReq-1:0]      elig;
  logic [NumReq-1:0]      inc;
  logic [NumReq-1:0]      dec;
  logic [ReqSelWidth-1:0] sel;
  logic [ReqSelWidth-1:0] rsel;
  logic                   gnt;
  logic                   q_hs;
  logic                   q_stall;
  logic                   rsel_ok;
  logic                   p_hs;
  dreq_t                  q_pay;
  dresp_t                 p_pay;

  always_comb begin
    for (int i = 0; i < int'(NumReq); i++) begin
      elig[i] = req_qvalid_i[i] && (cnt_q[i] != CntMax);
    end
  end

  tcdm_req_arbiter_rr_sel_lock #(
    .NumReq   (NumReq),
    .SelWidth (ReqSelWidth)
  ) u_sel (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .elig_i  (elig),
    .hs_i    (q_hs),
    .stall_i (q_stall),
    .sel_o   (sel),
    .gnt_o   (gnt)
  );

  assign q_hs    = data.qvalid && data.qready;
  assign q_stall = data.qvalid && !data.qready;

  assign q_pay = '{
    write: req_qwrite_i[sel],
    amo:   req_qamo_i[sel],
    data:  req_qdata_i[sel],
    strb:  req_qstrb_i[sel]
  };

  assign data.qvalid = rst_ni && gnt;
  assign data.qaddr  = req_qaddr_i[sel];
  assign data.qwrite = q_pay.write;
  assign data.qamo   = q_pay.amo;
  assign data.qdata  = q_pay.data;
  assign data.qstrb  = q_pay.strb;
  assign data.qid    = {sel, req_qid_i[sel]};

  // Responses carry the requester index in their MSBs
  assign rsel    = data.pid[MetaIdWidth-1 -: ReqSelWidth];
  assign rsel_ok = int'(rsel) < int'(NumReq);
  assign p_pay   = '{data: data.pdata, error: data.perror};

  assign data.pready = rst_ni &&
    (rsel_ok ? req_pready_i[rsel] : 1'b1);
  assign p_hs = data.pvalid && data.pready && rsel_ok;

  always_comb begin
    for (int i = 0; i < int'(NumReq); i++) begin
      req_qready_o[i] = rst_ni && gnt && data.qready &&
                        (sel == ReqSelWidth'(i));
      req_pvalid_o[i] = rst_ni && data.pvalid && rsel_ok &&
                        (rsel == ReqSelWidth'(i));
      req_pdata_o[i]  = p_pay.data;
      req_perror_o[i] = p_pay.error;
      req_pid_o[i]    = data.pid[ReqIdWidth-1:0];
      inc[i] = q_hs && (sel == ReqSelWidth'(i));
      dec[i] = p_hs && (rsel == ReqSelWidth'(i));
    end
  end

  // Counters saturate at zero so stale responses after reset are harmless
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumReq); i++) begin
        cnt_q[i] <= '0;
      end
      id_err_o <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NumReq); i++) begin
        assert (!(dec[i] && !inc[i] && cnt_q[i] == '0));
        if (inc[i] && !dec[i]) begin
          cnt_q[i] <= cnt_q[i] + CntWidth'(1);
        end else if (dec[i] && !inc[i] && cnt_q[i] != '0) begin
          cnt_q[i] <= cnt_q[i] - CntWidth'(1);
        end
      end
      if (data.pvalid && !rsel_ok) begin
        id_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tcdm_req_arbiter.sv
// Scoreboard bench for tcdm_req_arbiter at NumReq=3,
// MetaIdWidth=6 (2-bit requester index, 4-bit local id).
module tb_tcdm_req_arbiter;
  import tcdm_req_arbiter_pkg::*;

  localparam int NR = 3;
  localparam int MW = 6;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;

  logic [NR-1:0][31:0] req_qaddr;
  logic [NR-1:0][31:0] req_qdata;
  logic [NR-1:0][31:0] req_pdata;
  logic [NR-1:0][3:0]  req_qamo;
  logic [NR-1:0][3:0]  req_qstrb;
  logic [NR-1:0][3:0]  req_qid;
  logic [NR-1:0][3:0]  req_pid;
  logic [NR-1:0]       req_qwrite;
  logic [NR-1:0]       req_qvalid;
  logic [NR-1:0]       req_qready;
  logic [NR-1:0]       req_perror;
  logic [NR-1:0]       req_pvalid;
  logic [NR-1:0]       req_pready;
  logic                id_err;

  int total = 0;
  int bad = 0;

  logic [37:0] req_exp[$];
  logic [37:0] rsp_exp[$];

  always #5 clk = ~clk;

  tcdm_req_arbiter_if #(
    .AddrWidth(32), .DataWidth(32), .MetaIdWidth(MW)
  ) data_if ();

  tcdm_req_arbiter #(
    .NumReq(NR), .AddrWidth(32), .DataWidth(32),
    .MetaIdWidth(MW), .MaxOutstanding(8)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_qaddr_i  (req_qaddr),
    .req_qwrite_i (req_qwrite),
    .req_qamo_i   (req_qamo),
    .req_qdata_i  (req_qdata),
    .req_qstrb_i  (req_qstrb),
    .req_qid_i    (req_qid),
    .req_qvalid_i (req_qvalid),
    .req_qready_o (req_qready),
    .req_pdata_o  (req_pdata),
    .req_perror_o (req_perror),
    .req_pid_o    (req_pid),
    .req_pvalid_o (req_pvalid),
    .req_pready_i (req_pready),
    .data         (data_if),
    .id_err_o     (id_err)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clr();
    req_qvalid = '0;
    req_qaddr = '0;
    req_qdata = '0;
    req_qwrite = '0;
    req_qamo = '0;
    req_qstrb = '1;
    req_qid = '0;
    req_pready = '1;
    data_if.qready = 1'b1;
    data_if.pvalid = 1'b0;
    data_if.pid = '0;
    data_if.pdata = '0;
    data_if.perror = 1'b0;
  endtask

  task automatic send_rsp(input logic [1:0] r,
                          input logic [3:0] id,
                          input logic [31:0] d);
    data_if.pvalid = 1'b1;
    data_if.pid = {r, id};
    data_if.pdata = d;
    rsp_exp.push_back({r, id, d});
    step();
    data_if.pvalid = 1'b0;
  endtask

  // Monitor: pops expectations on every handshake
  always @(negedge clk) begin
    if (rst_ni && data_if.qvalid && data_if.qready) begin
      if (req_exp.size() == 0) begin
        total++;
        bad++;
        $display("FAIL req_sb: got %0h want none",
                 {data_if.qid, data_if.qaddr});
      end else begin
        chk("req_sb", {data_if.qid, data_if.qaddr},
            req_exp.pop_front());
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (req_pvalid[i] && req_pready[i]) begin
        if (rsp_exp.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_sb: got %0h want none",
                   {2'(i), req_pid[i], req_pdata[i]});
        end else begin
          chk("rsp_sb", {2'(i), req_pid[i], req_pdata[i]},
              rsp_exp.pop_front());
        end
      end
    end
  end

  logic       stall_q = 1'b0;
  logic [1:0] stall_sel_q = 2'd0;

  always @(posedge clk) begin
    stall_q <= rst_ni && data_if.qvalid && !data_if.qready;
    stall_sel_q <= data_if.qid[5:4];
  end

  always @(negedge clk) begin
    if (stall_q) begin
      assert (req_qvalid[stall_sel_q])
        else $error("requester dropped valid while stalled");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst_ni = 1'b0;
    req_qvalid = '1;
    data_if.pvalid = 1'b1;
    data_if.pid = 6'h05;
    step();
    chk("rst_qvalid", data_if.qvalid, 0);
    chk("rst_qready", req_qready, 0);
    chk("rst_pvalid", req_pvalid, 0);
    chk("rst_pready", data_if.pready, 0);
    chk("rst_id_err", id_err, 0);
    clr();
    step();
    rst_ni = 1'b1;
    step();

    // single requester round trip
    req_qvalid[0] = 1'b1;
    req_qid[0] = 4'd5;
    req_qaddr[0] = 32'h100;
    req_qdata[0] = 32'h11;
    req_exp.push_back({2'd0, 4'd5, 32'h100});
    settle();
    chk("single_qid", data_if.qid, 6'h05);
    chk("single_qready", req_qready, 3'b001);
    step();
    req_qvalid = '0;
    data_if.pvalid = 1'b1;
    data_if.pid = 6'h05;
    data_if.pdata = 32'hCAFE;
    rsp_exp.push_back({2'd0, 4'd5, 32'hCAFE});
    settle();
    chk("single_route", req_pvalid, 3'b001);
    step();
    data_if.pvalid = 1'b0;

    // fairness: pointer sits at 1 after req0
    req_qid[0] = 4'd1;
    req_qid[1] = 4'd2;
    for (int c = 0; c < 8; c++) begin
      req_qvalid[1:0] = 2'b11;
      req_qaddr[0] = 32'(32'h1000 + c);
      req_qaddr[1] = 32'(32'h2000 + c);
      if (c % 2 == 0)
        req_exp.push_back({2'd1, 4'd2, 32'(32'h2000 + c)});
      else
        req_exp.push_back({2'd0, 4'd1, 32'(32'h1000 + c)});
      settle();
      chk("fair_qready", req_qready,
          (c % 2 == 0) ? 3'b010 : 3'b001);
      step();
    end
    req_qvalid = '0;
    for (int k = 0; k < 4; k++) begin
      send_rsp(2'd0, 4'd1, 32'(32'hD000 + k));
      send_rsp(2'd1, 4'd2, 32'(32'hE000 + k));
    end

    // req2 moves the pointer to 0
    req_qvalid[2] = 1'b1;
    req_qid[2] = 4'd3;
    req_qaddr[2] = 32'h300;
    req_exp.push_back({2'd2, 4'd3, 32'h300});
    step();
    req_qvalid = '0;

    // lock: req1 stalls, req0 joins but must wait
    data_if.qready = 1'b0;
    req_qvalid[1] = 1'b1;
    req_qid[1] = 4'd4;
    req_qaddr[1] = 32'h404;
    settle();
    chk("lock_first", data_if.qid, {2'd1, 4'd4});
    step();
    req_qvalid[0] = 1'b1;
    req_qid[0] = 4'd6;
    req_qaddr[0] = 32'h500;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("lock_hold_id", data_if.qid, {2'd1, 4'd4});
      chk("lock_hold_addr", data_if.qaddr, 32'h404);
      chk("lock_hold_rdy", req_qready, 3'b000);
      step();
    end
    data_if.qready = 1'b1;
    req_exp.push_back({2'd1, 4'd4, 32'h404});
    settle();
    chk("lock_release", req_qready, 3'b010);
    step();
    req_qvalid[1] = 1'b0;
    req_exp.push_back({2'd0, 4'd6, 32'h500});
    settle();
    chk("after_lock", req_qready, 3'b001);
    step();
    req_qvalid = '0;
    send_rsp(2'd2, 4'd3, 32'h33);
    send_rsp(2'd1, 4'd4, 32'h44);
    send_rsp(2'd0, 4'd6, 32'h66);

    // outstanding limit on req0
    req_qvalid[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_qid[0] = 4'(k);
      req_qaddr[0] = 32'(32'h600 + 4 * k);
      req_exp.push_back({2'd0, 4'(k), 32'(32'h600 + 4 * k)});
      step();
    end
    req_qvalid[1] = 1'b1;
    req_qid[1] = 4'h7;
    req_qaddr[1] = 32'h6F0;
    req_exp.push_back({2'd1, 4'h7, 32'h6F0});
    settle();
    chk("limit_block", req_qready, 3'b010);
    step();
    req_qvalid[1] = 1'b0;
    settle();
    chk("limit_idle", data_if.qvalid, 0);
    step();
    data_if.pvalid = 1'b1;
    data_if.pid = {2'd0, 4'd0};
    data_if.pdata = 32'hF00;
    rsp_exp.push_back({2'd0, 4'd0, 32'hF00});
    settle();
    chk("limit_same_cyc", data_if.qvalid, 0);
    step();
    data_if.pvalid = 1'b0;
    req_qid[0] = 4'h8;
    req_qaddr[0] = 32'h700;
    req_exp.push_back({2'd0, 4'h8, 32'h700});
    settle();
    chk("limit_reopen", req_qready, 3'b001);
    step();
    req_qvalid = '0;
    for (int k = 1; k < 9; k++) begin
      send_rsp(2'd0, 4'(k), 32'(32'hA00 + k));
    end
    send_rsp(2'd1, 4'h7, 32'h777);

    // out-of-order responses with back-pressure
    req_qvalid[0] = 1'b1;
    req_qid[0] = 4'd1;
    req_qaddr[0] = 32'h800;
    req_exp.push_back({2'd0, 4'd1, 32'h800});
    step();
    req_qvalid = '0;
    req_qvalid[1] = 1'b1;
    req_qid[1] = 4'd2;
    req_qaddr[1] = 32'h804;
    req_exp.push_back({2'd1, 4'd2, 32'h804});
    step();
    req_qvalid = '0;
    req_pready[1] = 1'b0;
    data_if.pvalid = 1'b1;
    data_if.pid = {2'd1, 4'd2};
    data_if.pdata = 32'hB1;
    settle();
    chk("ooo_bp_pready", data_if.pready, 0);
    chk("ooo_bp_pvalid", req_pvalid, 3'b010);
    step();
    req_pready[1] = 1'b1;
    rsp_exp.push_back({2'd1, 4'd2, 32'hB1});
    settle();
    chk("ooo_release", data_if.pready, 1);
    step();
    data_if.pvalid = 1'b0;
    send_rsp(2'd0, 4'd1, 32'hA0);

    // illegal requester index
    chk("id_err_clean", id_err, 0);
    req_pready = '0;
    data_if.pvalid = 1'b1;
    data_if.pid = {2'd3, 4'h9};
    data_if.pdata = 32'hBAD;
    settle();
    chk("ill_pready", data_if.pready, 1);
    chk("ill_pvalid", req_pvalid, 0);
    step();
    data_if.pvalid = 1'b0;
    data_if.pid = '0;
    req_pready = '1;
    settle();
    chk("ill_err_set", id_err, 1);
    step();
    step();
    chk("ill_err_sticky", id_err, 1);
    rst_ni = 1'b0;
    step();
    chk("ill_err_clear", id_err, 0);
    rst_ni = 1'b1;
    step();

    chk("sb_req_drained", 64'(req_exp.size()), 0);
    chk("sb_rsp_drained", 64'(rsp_exp.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
